soc_system_pio_status: RTL

- Avalon-MM slave input PIO. It carries FPGA-side status bits to the HPS.
- It is the read-direction counterpart of the control-output PIOs on the lightweight HPS-to-FPGA bridge.
- It synchronizes `in_port`, detects and captures edges per bit, and raises a maskable level interrupt.
- Single `clk` domain; one instance per status group in `soc_system`.

---
 rtl/soc_system_pio_status_if.sv | 25 ++
 rtl/soc_system_pio_status.sv | 119 +++++++++++
 2 files changed

// File: rtl/soc_system_pio_status_if.sv
// Avalon-MM slave bus bundle for the status input PIO.
// The master drives address/strobe/data and the slave returns registered read data.
interface soc_system_pio_status_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/soc_system_pio_status.sv
// Status input PIO: synchronizes fabric status bits, captures the selected edge
// per bit into a W1C register and raises a maskable, registered level interrupt.
// Register map: 0 data_in (RO), 1 reserved (reads 0), 2 irq_mask (RW), 3 edge_capture (W1C).
module soc_system_pio_status #(
    parameter int WIDTH     = 8,
    parameter int EDGE_TYPE = 0,
    parameter int IRQ_MODE  = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    soc_system_pio_status_if.slave  avs,
    input  logic [WIDTH-1:0]        in_port,
    output logic                    irq
);

    localparam logic [1:0] EDGE_SEL = 2'(EDGE_TYPE);
    localparam logic       IRQ_EDGE = (IRQ_MODE == 1);

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_RSVD = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] irq_mask_q;
    logic [WIDTH-1:0] irq_mask_d;
    logic [WIDTH-1:0] edge_capture_q;
    logic [WIDTH-1:0] edge_capture_d;
    logic [31:0]      readdata_q;
    logic [31:0]      readdata_d;
    logic             irq_q;
    logic             irq_d;

    logic             wr_s;
    logic [WIDTH-1:0] wdata_s;
    logic [WIDTH-1:0] edge_s;
    logic [WIDTH-1:0] clr_s;

    assign wr_s    = avs.chipselect & ~avs.write_n;
    assign wdata_s = avs.writedata[WIDTH-1:0];

    // Two-flop synchronizer plus one history stage for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= in_port;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Select the configured edge polarity on the synchronized data.
    always_comb begin
        edge_s = '0;
        case (EDGE_SEL)
            2'd0:    edge_s = sync2_q & ~prev_q;
            2'd1:    edge_s = ~sync2_q & prev_q;
            default: edge_s = sync2_q ^ prev_q;
        endcase
    end

    // Next-state for mask and capture registers; a fresh edge beats a same-cycle clear.
    always_comb begin
        irq_mask_d = irq_mask_q;
        clr_s      = '0;
        if (wr_s && (avs.address == ADDR_MASK)) begin
            irq_mask_d = wdata_s;
        end else begin
            irq_mask_d = irq_mask_q;
        end
        if (wr_s && (avs.address == ADDR_EDGE)) begin
            clr_s = wdata_s;
        end else begin
            clr_s = '0;
        end
        edge_capture_d = edge_s | (edge_capture_q & ~clr_s);
    end

    // Read mux samples pre-write register values; interrupt source per IRQ_MODE.
    always_comb begin
        readdata_d = 32'h0000_0000;
        case (avs.address)
            ADDR_DATA: readdata_d = 32'(sync2_q);
            ADDR_RSVD: readdata_d = 32'h0000_0000;
            ADDR_MASK: readdata_d = 32'(irq_mask_q);
            ADDR_EDGE: readdata_d = 32'(edge_capture_q);
            default:   readdata_d = 32'h0000_0000;
        endcase
        if (IRQ_EDGE) begin
            irq_d = |(edge_capture_q & irq_mask_q);
        end else begin
            irq_d = |(sync2_q & irq_mask_q);
        end
    end

    // Architectural registers and registered bus/interrupt outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask_q     <= '0;
            edge_capture_q <= '0;
            readdata_q     <= 32'h0000_0000;
            irq_q          <= 1'b0;
        end else begin
            irq_mask_q     <= irq_mask_d;
            edge_capture_q <= edge_capture_d;
            readdata_q     <= readdata_d;
            irq_q          <= irq_d;
        end
    end

    assign avs.readdata = readdata_q;
    assign irq          = irq_q;

endmodule
